// File: rtl/stm_sequencer_pkg.sv
// Shared parameters, transition-mode constants and segment configuration
// type for the STM sequencer and its sibling sequencers.
package stm_sequencer_pkg;

  localparam int NUM_SEGMENT = 2;
  localparam int SEG_W       = $clog2(NUM_SEGMENT);
  localparam int IDX_W       = 13;
  localparam int DIV_W       = 16;
  localparam int REP_W       = 16;
  localparam int TIME_W      = 57;

  localparam logic [1:0] TRANSITION_MODE_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRANSITION_MODE_SYNC_IDX  = 2'd1;
  localparam logic [1:0] TRANSITION_MODE_SYS_TIME  = 2'd2;

  localparam logic [REP_W-1:0] REP_INFINITE = 16'hFFFF;

  typedef struct packed {
    logic [REP_W-1:0] rep;
    logic [IDX_W-1:0] cycle;
    logic [DIV_W-1:0] freq_div;
  } seg_cfg_t;

  // A divider of zero behaves like a divider of one.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/stm_sequencer_if.sv
// Request/status bundle between the settings block, the sequencer and the
// STM datapath. The master side drives requests and timing, the slave side
// is the sequencer.
interface stm_sequencer_if;
  import stm_sequencer_pkg::*;

  logic              UPDATE;
  logic [TIME_W-1:0] SYS_TIME;
  logic              SET_UPDATE;
  logic [SEG_W-1:0]  REQ_SEGMENT;
  logic [REP_W-1:0]  REQ_REP;
  logic [IDX_W-1:0]  REQ_CYCLE;
  logic [DIV_W-1:0]  REQ_FREQ_DIV;
  logic [1:0]        TRANSITION_MODE;
  logic [TIME_W-1:0] TRANSITION_VALUE;
  logic              BUSY;
  logic              START;
  logic [SEG_W-1:0]  SEGMENT;
  logic [IDX_W-1:0]  IDX;
  logic              FINISHED;
  logic              OVERRUN;

  modport master (
    output UPDATE, SYS_TIME, SET_UPDATE, REQ_SEGMENT, REQ_REP, REQ_CYCLE,
           REQ_FREQ_DIV, TRANSITION_MODE, TRANSITION_VALUE, BUSY,
    input  START, SEGMENT, IDX, FINISHED, OVERRUN
  );

  modport slave (
    input  UPDATE, SYS_TIME, SET_UPDATE, REQ_SEGMENT, REQ_REP, REQ_CYCLE,
           REQ_FREQ_DIV, TRANSITION_MODE, TRANSITION_VALUE, BUSY,
    output START, SEGMENT, IDX, FINISHED, OVERRUN
  );

endinterface

// File: rtl/stm_transition_check.sv
// Decides whether a pending segment transition is honoured on the current
// UPDATE. Shared with the modulation sequencer.
module stm_transition_check
  import stm_sequencer_pkg::*;
(
  input  logic [1:0]        mode_i,
  input  logic              wrap_i,
  input  logic [TIME_W-1:0] sys_time_i,
  input  logic [TIME_W-1:0] threshold_i,
  output logic              honour_o
);

  // Mode decode; the reserved encoding falls back to immediate.
  always_comb begin
    honour_o = 1'b0;
    case (mode_i)
      TRANSITION_MODE_SYNC_IDX: honour_o = wrap_i;
      TRANSITION_MODE_SYS_TIME: honour_o = (sys_time_i >= threshold_i);
      default:                  honour_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/stm_sequencer.sv
// STM sequencer: advances the sample index once per divided UPDATE period,
// applies repetition counts and segment transitions, and presents a stable
// {SEGMENT, IDX} pair to the datapath together with a START strobe.
module stm_sequencer
  import stm_sequencer_pkg::*;
(
  input logic            CLK,
  input logic            RST,
  stm_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FINISHED = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [SEG_W-1:0]  pend_seg_q, pend_seg_d;
  seg_cfg_t          pend_cfg_q, pend_cfg_d;
  logic [1:0]        pend_mode_q, pend_mode_d;
  logic [TIME_W-1:0] pend_value_q, pend_value_d;
  seg_cfg_t          act_q, act_d;        // act_q.rep is the remaining loop count
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              start_q, start_d;
  logic              fin_q, fin_d;
  logic              ovr_q, ovr_d;

  logic at_div_s, at_end_s, wrap_s, honour_s, take_s;

  assign at_div_s = (div_cnt_q == (eff_div(act_q.freq_div) - DIV_W'(1)));
  assign at_end_s = (idx_q == act_q.cycle);
  // A finished segment counts as wrapped so SYNC_IDX requests can leave it.
  assign wrap_s   = (state_q == ST_FINISHED) ? 1'b1 : (at_div_s & at_end_s);
  // The first request out of IDLE is taken regardless of its mode.
  assign take_s   = bus.UPDATE & pend_valid_q & ((state_q == ST_IDLE) | honour_s);

  stm_transition_check u_transition_check (
    .mode_i      (pend_mode_q),
    .wrap_i      (wrap_s),
    .sys_time_i  (bus.SYS_TIME),
    .threshold_i (pend_value_q),
    .honour_o    (honour_s)
  );

  // Next-state, index/divider/repetition update and pending-request bookkeeping.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_seg_d   = pend_seg_q;
    pend_cfg_d   = pend_cfg_q;
    pend_mode_d  = pend_mode_q;
    pend_value_d = pend_value_q;
    act_d        = act_q;
    div_cnt_d    = div_cnt_q;
    seg_d        = seg_q;
    idx_d        = idx_q;
    start_d      = 1'b0;
    fin_d        = fin_q;
    ovr_d        = ovr_q | (start_q & bus.BUSY);

    if (take_s) begin
      state_d   = ST_RUN;
      seg_d     = pend_seg_q;
      idx_d     = '0;
      div_cnt_d = '0;
      act_d     = pend_cfg_q;
      fin_d     = 1'b0;
      start_d   = 1'b1;
    end else if (bus.UPDATE) begin
      case (state_q)
        ST_RUN: begin
          start_d = 1'b1;
          if (at_div_s) begin
            div_cnt_d = '0;
            if (at_end_s) begin
              if (act_q.rep == '0) begin
                state_d = ST_FINISHED;
                fin_d   = 1'b1;
              end else begin
                idx_d = '0;
                if (act_q.rep != REP_INFINITE) begin
                  act_d.rep = act_q.rep - REP_W'(1);
                end else begin
                  act_d.rep = act_q.rep;
                end
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        ST_FINISHED: start_d = 1'b1;
        default:     start_d = 1'b0;
      endcase
    end else begin
      start_d = 1'b0;
    end

    // A new request is latched after the old one has been evaluated; last wins.
    if (bus.SET_UPDATE) begin
      pend_valid_d = 1'b1;
      pend_seg_d   = bus.REQ_SEGMENT;
      pend_cfg_d   = '{rep: bus.REQ_REP, cycle: bus.REQ_CYCLE, freq_div: bus.REQ_FREQ_DIV};
      pend_mode_d  = bus.TRANSITION_MODE;
      pend_value_d = bus.TRANSITION_VALUE;
    end else if (take_s) begin
      pend_valid_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_seg_q   <= '0;
      pend_cfg_q   <= '0;
      pend_mode_q  <= 2'd0;
      pend_value_q <= '0;
      act_q        <= '0;
      div_cnt_q    <= '0;
      seg_q        <= '0;
      idx_q        <= '0;
      start_q      <= 1'b0;
      fin_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_seg_q   <= pend_seg_d;
      pend_cfg_q   <= pend_cfg_d;
      pend_mode_q  <= pend_mode_d;
      pend_value_q <= pend_value_d;
      act_q        <= act_d;
      div_cnt_q    <= div_cnt_d;
      seg_q        <= seg_d;
      idx_q        <= idx_d;
      start_q      <= start_d;
      fin_q        <= fin_d;
      ovr_q        <= ovr_d;
    end
  end

  assign bus.START    = start_q;
  assign bus.SEGMENT  = seg_q;
  assign bus.IDX      = idx_q;
  assign bus.FINISHED = fin_q;
  assign bus.OVERRUN  = ovr_q;

endmodule

// File: tb/tb_stm_sequencer.sv
// Self-checking bench for stm_sequencer. The reference model tracks only the
// number of UPDATEs since the last honoured transition and derives the index
// and finished flag from it arithmetically.
module tb_stm_sequencer;
  import stm_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  stm_sequencer_if bus();

  stm_sequencer dut (.CLK(clk), .RST(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [TIME_W-1:0] sys_time;

  // Reference model state
  bit m_idle;
  int m_k, m_seg, m_cyc, m_div, m_rep;
  bit p_valid;
  int p_seg, p_cyc, p_div, p_rep, p_mode;
  logic [TIME_W-1:0] p_val;
  int s_seg, s_cyc, s_div, s_rep, s_mode;
  logic [TIME_W-1:0] s_val;
  // Expectations after the most recent UPDATE
  bit es, ef;
  int ei, eseg;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Index and finished flag k UPDATEs after a transition.
  function automatic void exp_at(input int k, input int cyc, input int dv, input int rp,
                                 output int idx, output bit fin);
    int n;
    n = k / eff(dv);
    if (rp != 65535 && n >= (rp + 1) * (cyc + 1)) begin
      idx = cyc;
      fin = 1'b1;
    end else begin
      idx = n % (cyc + 1);
      fin = 1'b0;
    end
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_k = 0; m_seg = 0; m_cyc = 0; m_div = 0; m_rep = 0;
    p_valid = 1'b0;
  endtask

  task automatic latch_staged();
    p_valid = 1'b1; p_seg = s_seg; p_cyc = s_cyc; p_div = s_div;
    p_rep = s_rep; p_mode = s_mode; p_val = s_val;
  endtask

  task automatic stage(input int seg, input int rep, input int cyc, input int dv,
                       input int mode, input logic [TIME_W-1:0] val);
    s_seg = seg; s_rep = rep; s_cyc = cyc; s_div = dv; s_mode = mode; s_val = val;
    bus.REQ_SEGMENT      = SEG_W'(seg);
    bus.REQ_REP          = REP_W'(rep);
    bus.REQ_CYCLE        = IDX_W'(cyc);
    bus.REQ_FREQ_DIV     = DIV_W'(dv);
    bus.TRANSITION_MODE  = 2'(mode);
    bus.TRANSITION_VALUE = val;
  endtask

  task automatic send_set();
    @(negedge clk);
    bus.SET_UPDATE = 1'b1;
    @(negedge clk);
    bus.SET_UPDATE = 1'b0;
    latch_staged();
  endtask

  // One UPDATE pulse; returns in the cycle where START is due.
  task automatic advance(input bit with_set);
    bit honour, ff;
    int fi;
    @(negedge clk);
    sys_time = sys_time + 57'd8;
    bus.SYS_TIME   = sys_time;
    bus.UPDATE     = 1'b1;
    bus.SET_UPDATE = with_set;
    @(negedge clk);
    bus.UPDATE     = 1'b0;
    bus.SET_UPDATE = 1'b0;
    honour = 1'b0;
    if (p_valid) begin
      if (m_idle) begin
        honour = 1'b1;
      end else begin
        exp_at(m_k, m_cyc, m_div, m_rep, fi, ff);
        case (p_mode)
          1:       honour = ff || (((m_k + 1) % (eff(m_div) * (m_cyc + 1))) == 0);
          2:       honour = (sys_time >= p_val);
          default: honour = 1'b1;
        endcase
      end
    end
    if (honour) begin
      m_idle = 1'b0; m_k = 0; m_seg = p_seg; m_cyc = p_cyc; m_div = p_div; m_rep = p_rep;
      p_valid = 1'b0;
    end else if (!m_idle) begin
      m_k = m_k + 1;
    end
    if (with_set) latch_staged();
    es = !m_idle;
    eseg = m_seg;
    if (m_idle) begin
      ei = 0; ef = 1'b0;
    end else begin
      exp_at(m_k, m_cyc, m_div, m_rep, ei, ef);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, bus.OVERRUN} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got START=%0b SEG=%0d IDX=%0d FIN=%0b OVR=%0b want all 0",
               bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, bus.OVERRUN);
    end
    for (int i = 0; i < 5; i++) begin
      advance(1'b0);
      checks++;
      if ({bus.START, bus.SEGMENT, bus.IDX} !== {1'b0, SEG_W'(0), IDX_W'(0)}) begin
        errors++;
        $display("FAIL idle_no_start tick %0d got START=%0b SEG=%0d IDX=%0d want 0/0/0",
                 i, bus.START, bus.SEGMENT, bus.IDX);
      end
    end
  endtask

  task automatic test_infinite();
    stage(0, 65535, 15, 1, 0, '0);
    send_set();
    for (int i = 0; i < 40; i++) begin
      advance(1'b0);
      checks++;
      if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED} !==
          {es, SEG_W'(eseg), IDX_W'(ei), ef} || bus.IDX !== IDX_W'(i % 16)) begin
        errors++;
        $display("FAIL infinite tick %0d got S=%0b SEG=%0d IDX=%0d FIN=%0b want S=%0b SEG=%0d IDX=%0d FIN=%0b",
                 i, bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, es, eseg, ei, ef);
      end
      @(negedge clk);
      checks++;
      if (bus.START !== 1'b0 || bus.IDX !== IDX_W'(ei)) begin
        errors++;
        $display("FAIL start_pulse tick %0d got START=%0b IDX=%0d want START=0 IDX=%0d",
                 i, bus.START, bus.IDX, ei);
      end
    end
  endtask

  task automatic test_finite();
    int want [16] = '{0,0,0,1,1,1,2,2,2,3,3,3,3,3,3,3};
    stage(1, 0, 3, 3, 0, '0);
    send_set();
    for (int i = 0; i < 16; i++) begin
      advance(1'b0);
      checks++;
      if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED} !==
          {es, SEG_W'(eseg), IDX_W'(ei), ef} || bus.IDX !== IDX_W'(want[i]) ||
          bus.FINISHED !== (i >= 12)) begin
        errors++;
        $display("FAIL finite tick %0d got S=%0b SEG=%0d IDX=%0d FIN=%0b want S=%0b SEG=%0d IDX=%0d FIN=%0b",
                 i, bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, es, eseg, ei, ef);
      end
    end
  endtask

  task automatic test_sync_idx();
    int first_switch;
    stage(0, 65535, 15, 1, 0, '0);
    send_set();
    for (int i = 0; i < 6; i++) advance(1'b0);
    checks++;
    if (bus.IDX !== IDX_W'(5)) begin
      errors++;
      $display("FAIL sync_setup got IDX=%0d want 5", bus.IDX);
    end
    stage(1, 65535, 7, 1, 1, '0);
    send_set();
    first_switch = -1;
    for (int i = 1; i <= 14; i++) begin
      advance(1'b0);
      if (first_switch < 0 && bus.SEGMENT === 1'b1) first_switch = i;
      checks++;
      if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED} !==
          {es, SEG_W'(eseg), IDX_W'(ei), ef}) begin
        errors++;
        $display("FAIL sync_idx tick %0d got S=%0b SEG=%0d IDX=%0d want S=%0b SEG=%0d IDX=%0d",
                 i, bus.START, bus.SEGMENT, bus.IDX, es, eseg, ei);
      end
    end
    checks++;
    if (first_switch != 11) begin
      errors++;
      $display("FAIL sync_switch_tick got %0d want 11", first_switch);
    end
  endtask

  task automatic test_sys_time();
    int first_switch;
    stage(0, 65535, 15, 2, 2, sys_time + 57'd80);
    send_set();
    first_switch = -1;
    for (int i = 1; i <= 14; i++) begin
      advance(1'b0);
      if (first_switch < 0 && bus.SEGMENT === 1'b0) first_switch = i;
      checks++;
      if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED} !==
          {es, SEG_W'(eseg), IDX_W'(ei), ef}) begin
        errors++;
        $display("FAIL sys_time tick %0d got S=%0b SEG=%0d IDX=%0d want S=%0b SEG=%0d IDX=%0d",
                 i, bus.START, bus.SEGMENT, bus.IDX, es, eseg, ei);
      end
    end
    checks++;
    if (first_switch != 10) begin
      errors++;
      $display("FAIL sys_time_switch_tick got %0d want 10", first_switch);
    end
  endtask

  task automatic test_same_cycle_set();
    stage(1, 65535, 5, 1, 0, '0);
    advance(1'b1);
    checks++;
    if (bus.SEGMENT !== 1'b0 || bus.SEGMENT !== SEG_W'(eseg)) begin
      errors++;
      $display("FAIL same_cycle_hold got SEG=%0d want 0", bus.SEGMENT);
    end
    advance(1'b0);
    checks++;
    if ({bus.SEGMENT, bus.IDX} !== {SEG_W'(eseg), IDX_W'(ei)} || bus.SEGMENT !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_take got SEG=%0d IDX=%0d want SEG=%0d IDX=%0d",
               bus.SEGMENT, bus.IDX, eseg, ei);
    end
  endtask

  task automatic test_random();
    int reps [4] = '{0, 1, 2, 65535};
    for (int r = 0; r < 8; r++) begin
      stage($urandom_range(0, 1), reps[$urandom_range(0, 3)], $urandom_range(0, 9),
            $urandom_range(0, 3), $urandom_range(0, 3), sys_time + 57'($urandom_range(0, 100)));
      if ($urandom_range(0, 1) == 1) send_set();
      else advance(1'b1);
      for (int i = 0; i < int'($urandom_range(10, 30)); i++) begin
        advance(1'b0);
        checks++;
        if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED} !==
            {es, SEG_W'(eseg), IDX_W'(ei), ef}) begin
          errors++;
          $display("FAIL random r%0d tick %0d got S=%0b SEG=%0d IDX=%0d FIN=%0b want S=%0b SEG=%0d IDX=%0d FIN=%0b",
                   r, i, bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, es, eseg, ei, ef);
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic test_overrun_and_reset();
    stage(1, 65535, 9, 2, 0, '0);
    send_set();
    advance(1'b0);
    checks++;
    if (bus.OVERRUN !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got %0b want 0", bus.OVERRUN);
    end
    bus.BUSY = 1'b1;
    advance(1'b0);
    @(negedge clk);
    bus.BUSY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.OVERRUN !== 1'b1) begin
        errors++;
        $display("FAIL overrun_sticky step %0d got %0b want 1", i, bus.OVERRUN);
      end
      advance(1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, bus.OVERRUN} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got START=%0b SEG=%0d IDX=%0d FIN=%0b OVR=%0b want all 0",
               bus.START, bus.SEGMENT, bus.IDX, bus.FINISHED, bus.OVERRUN);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      advance(1'b0);
      checks++;
      if ({bus.START, bus.IDX} !== {es, IDX_W'(ei)} || bus.START !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle tick %0d got START=%0b IDX=%0d want 0/0", i, bus.START, bus.IDX);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sys_time = '0;
    bus.UPDATE = 1'b0; bus.SYS_TIME = '0; bus.SET_UPDATE = 1'b0; bus.BUSY = 1'b0;
    stage(0, 0, 0, 0, 0, '0);
    model_reset();
    test_reset();
    test_infinite();
    test_finite();
    test_sync_idx();
    test_sys_time();
    test_same_cycle_set();
    test_random();
    test_overrun_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
